// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encodings and lamp constants for the traffic phase sequencer
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_ALL_RED_1 = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_ALL_RED_2 = 3'd5,
        PH_PED_WALK  = 3'd6
    } phase_t;

    // Lamp bundles are {red, yellow, green}, one-hot.
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - sequencer signal bundle; ped_req/walk present only with TRAFFIC_PED_WALK_EN
interface traffic_phase_ctrl_if;

    logic       tick;
    logic       ew_sensor;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic       phase_done;
`ifdef TRAFFIC_PED_WALK_EN
    logic       ped_req;
    logic       walk;

    modport master (
        output tick, ew_sensor, ped_req,
        input  ns_light, ew_light, phase, phase_done, walk
    );

    modport slave (
        input  tick, ew_sensor, ped_req,
        output ns_light, ew_light, phase, phase_done, walk
    );
`else
    modport master (
        output tick, ew_sensor,
        input  ns_light, ew_light, phase, phase_done
    );

    modport slave (
        input  tick, ew_sensor,
        output ns_light, ew_light, phase, phase_done
    );
`endif

endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - tick-counted phase dwell timer; expire is combinational on the final tick
module dwell_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] dur,
    output logic             expire
);

    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] last;

    // A zero duration behaves like a one-tick phase.
    assign last   = (dur == '0) ? '0 : dur - CNT_W'(1);
    assign expire = tick && (n == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            n <= '0;
        end else if (expire) begin
            n <= '0;
        end else if (tick) begin
            n <= n + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - NS/EW phase sequencer with EW demand; pedestrian walk under TRAFFIC_PED_WALK_EN
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_GREEN  = 20,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_RED    = 1,
    parameter int unsigned T_WALK   = 8
) (
    input  logic               clk,
    input  logic               rst,
    traffic_phase_ctrl_if.slave bus
);

    phase_t           state_q;
    phase_t           state_d;
    logic [CNT_W-1:0] dur;
    logic             expire;
    logic             clr;
    logic             ew_dem;
    logic             done_q;
    logic             walk_lamp;
    logic             ped_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_ALL_RED_2;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    logic ped_dem;

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_dem <= 1'b0;
        end else if (state_d == PH_PED_WALK && state_q != PH_PED_WALK) begin
            ped_dem <= 1'b0;
        end else if (bus.ped_req) begin
            ped_dem <= 1'b1;
        end
    end

    assign ped_go   = ped_dem;
    assign bus.walk = walk_lamp;
`else
    assign ped_go = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_NS_GREEN:  if (expire && ew_dem) state_d = PH_NS_YELLOW;
            PH_NS_YELLOW: if (expire) state_d = PH_ALL_RED_1;
            PH_ALL_RED_1: if (expire) state_d = PH_EW_GREEN;
            PH_EW_GREEN:  if (expire) state_d = PH_EW_YELLOW;
            PH_EW_YELLOW: if (expire) state_d = PH_ALL_RED_2;
            PH_ALL_RED_2: if (expire) state_d = ped_go ? PH_PED_WALK : PH_NS_GREEN;
`ifdef TRAFFIC_PED_WALK_EN
            PH_PED_WALK:  if (expire) state_d = PH_NS_GREEN;
`endif
            default:      state_d = PH_ALL_RED_2;
        endcase
    end

    always_comb begin
        bus.ns_light = LT_RED;
        bus.ew_light = LT_RED;
        walk_lamp    = 1'b0;
        case (state_q)
            PH_NS_GREEN:  bus.ns_light = LT_GRN;
            PH_NS_YELLOW: bus.ns_light = LT_YEL;
            PH_EW_GREEN:  bus.ew_light = LT_GRN;
            PH_EW_YELLOW: bus.ew_light = LT_YEL;
            PH_PED_WALK:  walk_lamp    = 1'b1;
            default:      ;
        endcase
    end

    always_comb begin
        dur = CNT_W'(T_RED);
        case (state_q)
            PH_NS_GREEN, PH_EW_GREEN:   dur = CNT_W'(T_GREEN);
            PH_NS_YELLOW, PH_EW_YELLOW: dur = CNT_W'(T_YELLOW);
            PH_PED_WALK:                dur = CNT_W'(T_WALK);
            default:                    dur = CNT_W'(T_RED);
        endcase
    end

    // Restarting the timer on every state change keeps each phase's count independent.
    assign clr = (state_d != state_q);

    dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .tick   (bus.tick),
        .dur    (dur),
        .expire (expire)
    );

    // The clear on entry to EW_GREEN takes priority over a coincident sensor hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ew_dem <= 1'b0;
        end else if (state_d == PH_EW_GREEN && state_q != PH_EW_GREEN) begin
            ew_dem <= 1'b0;
        end else if (bus.ew_sensor) begin
            ew_dem <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= expire;
        end
    end

    assign bus.phase      = state_q;
    assign bus.phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed bench for traffic_phase_ctrl; pedestrian steps need TRAFFIC_PED_WALK_EN
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    traffic_phase_ctrl_if bus ();

    traffic_phase_ctrl #(
        .CNT_W(8), .T_GREEN(4), .T_YELLOW(2), .T_RED(1), .T_WALK(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are read 1ns after the edge and the lamp invariant is checked.
    task automatic step();
        @(posedge clk);
        #1;
        check("invariant", 8'((bus.ns_light != 3'b100) && (bus.ew_light != 3'b100)), 8'd0);
    endtask

    task automatic wait_phase(input string tag, input logic [2:0] p, input int lim);
        int k = 0;
        while (bus.phase !== p && k < lim) begin
            step();
            k++;
        end
        check(tag, 8'(bus.phase), 8'(p));
    endtask

    logic [2:0] exp_ph [12] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0};
    logic [2:0] exp_ew [12] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001,
                                3'b010, 3'b010, 3'b100, 3'b100};

    initial begin
        int pulses;
        int ycnt;
        rst           = 1'b1;
        bus.tick      = 1'b1;
        bus.ew_sensor = 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
        bus.ped_req   = 1'b0;
`endif
        step();
        step();
        check("rst_phase", 8'(bus.phase), 8'd5);
        check("rst_ns", 8'(bus.ns_light), 8'h4);
        check("rst_ew", 8'(bus.ew_light), 8'h4);
        check("rst_done", 8'(bus.phase_done), 8'd0);
`ifdef TRAFFIC_PED_WALK_EN
        check("rst_walk", 8'(bus.walk), 8'd0);
`endif

        rst = 1'b0;
        step();
        check("rel_phase", 8'(bus.phase), 8'd0);
        check("rel_ns", 8'(bus.ns_light), 8'h1);
        check("rel_done", 8'(bus.phase_done), 8'd1);
        step();
        check("rel_done_low", 8'(bus.phase_done), 8'd0);

        // No demand: green re-arms every 4 ticks.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("nodem_phase", 8'(bus.phase), 8'd0);
            check("nodem_ew", 8'(bus.ew_light), 8'h4);
            check("nodem_done", 8'(bus.phase_done), 8'(((i + 2) % 4) == 0));
            if (bus.phase_done) pulses++;
        end
        check("nodem_pulses", 8'(pulses), 8'd5);

        // One-cycle EW request, then the full service cycle.
        bus.ew_sensor = 1'b1;
        step();
        bus.ew_sensor = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("svc_phase", 8'(bus.phase), 8'(exp_ph[i]));
            check("svc_ew", 8'(bus.ew_light), 8'(exp_ew[i]));
        end

        // Sparse tick: one tick per 5 cycles stretches NS_YELLOW to 10 cycles.
        bus.ew_sensor = 1'b1;
        ycnt = 0;
        for (int c = 0; c < 300; c++) begin
            bus.tick = ((c % 5) == 0);
            step();
            if (bus.phase == 3'd1) ycnt++;
            if (ycnt > 0 && bus.phase != 3'd1) break;
        end
        bus.tick      = 1'b1;
        bus.ew_sensor = 1'b0;
        check("sparse_yel_len", 8'(ycnt), 8'd10);
        check("sparse_next", 8'(bus.phase), 8'd2);

        // Reset two ticks into EW_GREEN with a pending EW demand.
        wait_phase("reach_ewg", 3'd3, 40);
        bus.ew_sensor = 1'b1;
        step();
        bus.ew_sensor = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_phase", 8'(bus.phase), 8'd5);
        check("mid_rst_ns", 8'(bus.ns_light), 8'h4);
        check("mid_rst_ew", 8'(bus.ew_light), 8'h4);
        step();
        check("mid_rst_ns_green", 8'(bus.phase), 8'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("mid_rst_rest", 8'(bus.phase), 8'd0);
        end

`ifdef TRAFFIC_PED_WALK_EN
        bus.ew_sensor = 1'b1;
        step();
        bus.ew_sensor = 1'b0;
        wait_phase("ped_reach_ewg", 3'd3, 40);
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        wait_phase("ped_reach_ar2", 3'd5, 40);
        // Press coinciding with entry into PED_WALK must be discarded.
        bus.ped_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.ped_req = 1'b0;
            check("walk_phase", 8'(bus.phase), 8'd6);
            check("walk_lamp", 8'(bus.walk), 8'd1);
            check("walk_ns", 8'(bus.ns_light), 8'h4);
            check("walk_ew", 8'(bus.ew_light), 8'h4);
        end
        step();
        check("walk_end_phase", 8'(bus.phase), 8'd0);
        check("walk_end_lamp", 8'(bus.walk), 8'd0);
        bus.ew_sensor = 1'b1;
        step();
        bus.ew_sensor = 1'b0;
        wait_phase("ped2_reach_ar2", 3'd5, 40);
        step();
        check("ped_dropped", 8'(bus.phase), 8'd0);
        check("ped_dropped_walk", 8'(bus.walk), 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
